// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Fetch/decode/execute controller for the 8-bit accumulator
//                CPU; consumes an instruction byte stream, drives datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int PC_STEP  = 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                rf_we,
    output logic [2:0]          rf_waddr,
    output logic [2:0]          rf_raddr1,
    output logic [2:0]          rf_raddr2,
    output logic                rf_wsel_mem,
    output logic [2:0]          alu_op,
    output logic                is_add,
    output logic                is_imm,
    output logic [7:0]          imm,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_rd,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_OPERAND = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM_RD  = 3'd3,
        S_MEM_WB  = 3'd4
    } state_t;

    localparam logic [2:0] c_OP_LDI = 3'd0;
    localparam logic [2:0] c_OP_MOV = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_SUB = 3'd3;
    localparam logic [2:0] c_OP_AND = 3'd4;
    localparam logic [2:0] c_OP_OR  = 3'd5;
    localparam logic [2:0] c_OP_ST  = 3'd6;
    localparam logic [2:0] c_OP_LD  = 3'd7;
    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(PC_STEP);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_ir;
    logic [7:0]          w_ir_nxt;
    logic [7:0]          w_imm_nxt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic                w_err_nxt;
    logic                w_xfer;
    logic [2:0]          w_op_cur;
    logic [2:0]          w_op_nxt;

    logic       w_rf_we, w_wsel_mem, w_is_add, w_is_imm;
    logic       w_ram_cs, w_ram_we, w_ram_rd;
    logic [2:0] w_alu_op;

    assign w_xfer   = in_valid && ((r_state == S_FETCH) || (r_state == S_OPERAND));
    assign w_op_cur = r_ir[7:5];
    assign w_op_nxt = w_ir_nxt[7:5];

    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_imm_nxt   = imm;
        w_pc_nxt    = pc;
        w_err_nxt   = err;
        case (r_state)
            S_FETCH: begin
                if (w_xfer) begin
                    // A byte with the reserved bit set is flagged and dropped.
                    if (in_data[0]) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_ir_nxt = in_data;
                        if ((in_data[7:5] == c_OP_LDI) || (in_data[7:5] == c_OP_ST) ||
                            (in_data[7:5] == c_OP_LD))
                            w_state_nxt = S_OPERAND;
                        else
                            w_state_nxt = S_EXEC;
                    end
                end
            end
            S_OPERAND: begin
                if (w_xfer) begin
                    w_imm_nxt   = in_data;
                    w_state_nxt = (w_op_cur == c_OP_LD) ? S_MEM_RD : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = pc + c_PC_STEP;
            end
            S_MEM_RD: w_state_nxt = S_MEM_WB;
            S_MEM_WB: begin
                w_state_nxt = S_FETCH;
                w_pc_nxt    = pc + c_PC_STEP;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Controls are decoded from the upcoming state so they register alongside it.
    always_comb begin
        w_rf_we    = 1'b0;
        w_wsel_mem = 1'b0;
        w_is_add   = 1'b1;
        w_is_imm   = 1'b0;
        w_ram_cs   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_rd   = 1'b0;
        w_alu_op   = 3'b000;
        case (w_state_nxt)
            S_EXEC: begin
                case (w_op_nxt)
                    c_OP_LDI: begin w_is_imm = 1'b1; w_rf_we = 1'b1; end
                    c_OP_MOV: w_rf_we = 1'b1;
                    c_OP_ADD: begin w_alu_op = 3'b001; w_rf_we = 1'b1; end
                    c_OP_SUB: begin w_alu_op = 3'b001; w_is_add = 1'b0; w_rf_we = 1'b1; end
                    c_OP_AND: begin w_alu_op = 3'b010; w_rf_we = 1'b1; end
                    c_OP_OR:  begin w_alu_op = 3'b011; w_rf_we = 1'b1; end
                    c_OP_ST:  begin w_ram_cs = 1'b1; w_ram_we = 1'b1; end
                    default:  w_rf_we = 1'b0;
                endcase
            end
            S_MEM_RD: begin
                w_ram_cs = 1'b1;
                w_ram_rd = 1'b1;
            end
            S_MEM_WB: begin
                w_ram_cs   = 1'b1;
                w_ram_rd   = 1'b1;
                w_rf_we    = 1'b1;
                w_wsel_mem = 1'b1;
            end
            default: w_rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_FETCH;
            r_ir        <= '0;
            imm         <= '0;
            pc          <= '0;
            err         <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            rf_we       <= 1'b0;
            rf_wsel_mem <= 1'b0;
            is_add      <= 1'b1;
            is_imm      <= 1'b0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_rd      <= 1'b0;
            alu_op      <= 3'b000;
            rf_waddr    <= 3'b000;
            rf_raddr1   <= 3'b000;
            rf_raddr2   <= 3'b000;
        end else begin
            r_state     <= w_state_nxt;
            r_ir        <= w_ir_nxt;
            imm         <= w_imm_nxt;
            pc          <= w_pc_nxt;
            err         <= w_err_nxt;
            in_ready    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_OPERAND);
            busy        <= (w_state_nxt != S_FETCH);
            rf_we       <= w_rf_we;
            rf_wsel_mem <= w_wsel_mem;
            is_add      <= w_is_add;
            is_imm      <= w_is_imm;
            ram_cs      <= w_ram_cs;
            ram_we      <= w_ram_we;
            ram_rd      <= w_ram_rd;
            alu_op      <= w_alu_op;
            rf_waddr    <= {1'b0, w_ir_nxt[4:3]};
            rf_raddr1   <= {1'b0, w_ir_nxt[4:3]};
            rf_raddr2   <= {1'b0, w_ir_nxt[2:1]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench; instruction-level cycle-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic       CLK, RESET;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic       rf_we, rf_wsel_mem, is_add, is_imm, ram_cs, ram_we, ram_rd, busy, err;
    logic [2:0] rf_waddr, rf_raddr1, rf_raddr2, alu_op;
    logic [7:0] imm;
    logic [7:0] pc;

    cpu_sequencer #(.PC_WIDTH(8), .PC_STEP(1)) dut (
        .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_wsel_mem(rf_wsel_mem), .alu_op(alu_op),
        .is_add(is_add), .is_imm(is_imm), .imm(imm), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_rd(ram_rd), .pc(pc), .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One record per busy cycle an instruction will occupy.
    typedef struct {
        logic       rf_we, wsel, is_add, is_imm, cs, we, rd;
        logic [2:0] alu, wa, ra1, ra2;
        bit         chk_ra, retire;
    } rec_t;

    rec_t q[$];
    rec_t exp_r;
    rec_t idle_r;
    int   m_pc      = 0;
    logic [7:0] m_imm = 0;
    bit   m_err     = 0;
    bit   m_have_op = 0;
    logic [7:0] m_op_byte = 0;
    bit   m_live    = 0;
    bit   m_wrapped = 0;

    function automatic rec_t blank();
        rec_t r;
        r.rf_we = 0; r.wsel = 0; r.is_add = 1; r.is_imm = 0;
        r.cs = 0; r.we = 0; r.rd = 0; r.alu = 3'd0;
        r.wa = 0; r.ra1 = 0; r.ra2 = 0; r.chk_ra = 0; r.retire = 0;
        return r;
    endfunction

    function automatic rec_t exec_rec(input logic [7:0] b);
        rec_t r = blank();
        logic [2:0] op = b[7:5];
        r.wa = {1'b0, b[4:3]}; r.ra1 = {1'b0, b[4:3]}; r.ra2 = {1'b0, b[2:1]};
        r.chk_ra = 1; r.retire = 1;
        r.rf_we  = (op <= 3'd5);
        r.is_imm = (op == 3'd0);
        r.is_add = (op != 3'd3);
        r.alu    = (op == 3'd2 || op == 3'd3) ? 3'd1 : (op == 3'd4) ? 3'd2 : (op == 3'd5) ? 3'd3 : 3'd0;
        r.cs     = (op == 3'd6);
        r.we     = (op == 3'd6);
        return r;
    endfunction

    always @(posedge CLK) begin : model
        rec_t r;
        if (RESET) begin
            q.delete(); m_pc = 0; m_imm = 0; m_err = 0; m_have_op = 0; m_op_byte = 0; m_live = 1;
        end else if (m_live) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                if (r.retire) begin
                    if (m_pc == 255) m_wrapped = 1;
                    m_pc = (m_pc + 1) % 256;
                end
            end else if (in_valid) begin
                if (!m_have_op) begin
                    if (in_data[0]) m_err = 1;
                    else if (in_data[7:5] == 3'd0 || in_data[7:5] == 3'd6 || in_data[7:5] == 3'd7) begin
                        m_have_op = 1; m_op_byte = in_data;
                    end else q.push_back(exec_rec(in_data));
                end else begin
                    m_imm = in_data; m_have_op = 0;
                    if (m_op_byte[7:5] == 3'd7) begin
                        r = blank(); r.cs = 1; r.rd = 1;
                        q.push_back(r);
                        r.rf_we = 1; r.wsel = 1; r.wa = {1'b0, m_op_byte[4:3]}; r.retire = 1;
                        q.push_back(r);
                    end else q.push_back(exec_rec(m_op_byte));
                end
            end
        end
    end

    always @(negedge CLK) begin : compare
        if (m_live) begin
            idle_r = blank();
            exp_r  = (q.size() > 0) ? q[0] : idle_r;
            cmp("in_ready", in_ready, q.size() == 0);
            cmp("busy", busy, (q.size() > 0) || m_have_op);
            cmp("pc", pc, m_pc);
            cmp("err", err, m_err);
            cmp("imm", imm, m_imm);
            cmp("rf_we", rf_we, exp_r.rf_we);
            cmp("rf_wsel_mem", rf_wsel_mem, exp_r.wsel);
            cmp("is_add", is_add, exp_r.is_add);
            cmp("is_imm", is_imm, exp_r.is_imm);
            cmp("alu_op", alu_op, exp_r.alu);
            cmp("ram_cs", ram_cs, exp_r.cs);
            cmp("ram_we", ram_we, exp_r.we);
            cmp("ram_rd", ram_rd, exp_r.rd);
            if (exp_r.chk_ra) begin
                cmp("rf_raddr1", rf_raddr1, exp_r.ra1);
                cmp("rf_raddr2", rf_raddr2, exp_r.ra2);
            end
            if (exp_r.rf_we) cmp("rf_waddr", rf_waddr, exp_r.wa);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        logic [1:0] dst, src;
        logic       b0;
        RESET = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        RESET = 1'b0;
        cmp("rst_in_ready", in_ready, 1); cmp("rst_busy", busy, 0); cmp("rst_pc", pc, 0);
        cmp("rst_err", err, 0); cmp("rst_imm", imm, 0); cmp("rst_rf_we", rf_we, 0);
        cmp("rst_is_add", is_add, 1);

        put(8'h00); put(8'h5A);
        cmp("ldi_we", rf_we, 1); cmp("ldi_waddr", rf_waddr, 0); cmp("ldi_imm", imm, 8'h5A);
        cmp("ldi_is_imm", is_imm, 1); cmp("ldi_ready", in_ready, 0);
        tick(); cmp("ldi_pc", pc, 1); cmp("ldi_idle", busy, 0);

        put(8'h48);
        cmp("add_alu", alu_op, 1); cmp("add_is_add", is_add, 1); cmp("add_ra1", rf_raddr1, 1);
        cmp("add_ra2", rf_raddr2, 0); cmp("add_we", rf_we, 1);
        tick(); cmp("add_pc", pc, 2);

        put(8'h6A);
        cmp("sub_is_add", is_add, 0); cmp("sub_alu", alu_op, 1); cmp("sub_ready", in_ready, 0);
        tick(); cmp("sub_pc", pc, 3);

        put(8'hC2); put(8'h07);
        cmp("st_we", ram_we, 1); cmp("st_cs", ram_cs, 1); cmp("st_imm", imm, 7);
        cmp("st_rf_we", rf_we, 0); cmp("st_rd", ram_rd, 0);
        tick(); cmp("st_pc", pc, 4);

        put(8'hE8); put(8'h07);
        cmp("ldrd_cs", ram_cs, 1); cmp("ldrd_rd", ram_rd, 1); cmp("ldrd_we", ram_we, 0);
        cmp("ldrd_rf_we", rf_we, 0);
        tick();
        cmp("ldwb_rf_we", rf_we, 1); cmp("ldwb_wsel", rf_wsel_mem, 1); cmp("ldwb_waddr", rf_waddr, 1);
        cmp("ldwb_pc", pc, 4);
        tick(); cmp("ld_pc", pc, 5); cmp("ld_busy", busy, 0);

        put(8'h01);
        cmp("bad_err", err, 1); cmp("bad_busy", busy, 0); cmp("bad_pc", pc, 5);
        cmp("bad_rf_we", rf_we, 0); cmp("bad_cs", ram_cs, 0); cmp("bad_ready", in_ready, 1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        cmp("clr_err", err, 0); cmp("clr_pc", pc, 0);

        put(8'hE8);
        cmp("opnd_busy", busy, 1); cmp("opnd_ready", in_ready, 1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        cmp("abort_busy", busy, 0); cmp("abort_pc", pc, 0); cmp("abort_cs", ram_cs, 0);
        tick();
        cmp("abort_rf_we", rf_we, 0); cmp("abort_rd", ram_rd, 0); cmp("abort_ready", in_ready, 1);

        for (int c = 0; c < 4000; c++) begin
            RESET    = (c > 1500) && ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            if (m_have_op) begin
                in_data = 8'($urandom_range(0, 255));
            end else begin
                op  = 3'($urandom_range(0, 7));
                dst = 2'($urandom_range(0, 3));
                src = 2'($urandom_range(0, 3));
                b0  = ($urandom_range(0, 15) == 0);
                in_data = {op, dst, src, b0};
            end
            tick();
        end
        RESET = 1'b0; in_valid = 1'b0;
        tick();
        cmp("pc_wrap_seen", m_wrapped, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
